// File: rtl/wb_pkg.sv
// Shared widths, defaults and the buffered writeback entry type
// for the register-file write-port arbiter.
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_AW     = 5;
    localparam int FIFO_DEPTH = 2;
    localparam int NREGS      = 1 << REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer holding multi-cycle results that are waiting
// for the register-file write port.
module wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);
    assign head_o  = r_mem[r_rd_ptr];

    // Guards keep the pointers sane even if a caller misbehaves.
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline
// and buffered multi-cycle results; tracks pending multi-cycle writes.
module wb_arbiter #(
    parameter int XLEN       = wb_pkg::XLEN,
    parameter int FIFO_DEPTH = wb_pkg::FIFO_DEPTH
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      pipe_wren,
    input  logic [wb_pkg::REG_AW-1:0] pipe_rd_addr,
    input  logic [XLEN-1:0]           pipe_rd_data,
    output logic                      pipe_stall,
    input  logic                      mc_issue,
    input  logic [wb_pkg::REG_AW-1:0] mc_issue_rd,
    input  logic                      mc_valid,
    output logic                      mc_ready,
    input  logic [wb_pkg::REG_AW-1:0] mc_rd_addr,
    input  logic [XLEN-1:0]           mc_rd_data,
    input  logic [wb_pkg::REG_AW-1:0] rs1_addr,
    input  logic [wb_pkg::REG_AW-1:0] rs2_addr,
    output logic                      busy_rs1,
    output logic                      busy_rs2,
    output logic                      rd_wren,
    output logic [wb_pkg::REG_AW-1:0] rd_addr,
    output logic [XLEN-1:0]           rd_data
);

    import wb_pkg::*;

    localparam int EW = REG_AW + XLEN;

    logic [EW-1:0]     w_head;
    logic [REG_AW-1:0] w_head_addr;
    logic [XLEN-1:0]   w_head_data;
    logic              w_full;
    logic              w_empty;
    logic              w_pipe_ok;
    logic              w_pop;
    logic              w_sel_pipe;
    logic              w_push;
    logic [NREGS-1:0]  w_busy_nxt;

    logic [NREGS-1:0]  r_busy;
    logic              r_rd_wren;
    logic [REG_AW-1:0] r_rd_addr;
    logic [XLEN-1:0]   r_rd_data;

    wb_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (w_push),
        .push_data_i ({mc_rd_addr, mc_rd_data}),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    assign w_head_addr = w_head[EW-1 -: REG_AW];
    assign w_head_data = w_head[XLEN-1:0];

    // A full buffer always wins so the multi-cycle unit can make progress.
    assign w_pipe_ok  = pipe_wren && (pipe_rd_addr != '0);
    assign w_pop      = w_full || (!w_pipe_ok && !w_empty);
    assign w_sel_pipe = !w_full && w_pipe_ok;

    assign mc_ready   = !w_full;
    assign pipe_stall = w_full;
    assign w_push     = mc_valid && !w_full && (mc_rd_addr != '0);

    // Clear before set: a re-issue in the pop cycle keeps the bit pending.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop) begin
            w_busy_nxt[w_head_addr] = 1'b0;
        end
        if (mc_issue && (mc_issue_rd != '0)) begin
            w_busy_nxt[mc_issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy    <= '0;
            r_rd_wren <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_pop) begin
                r_rd_wren <= 1'b1;
                r_rd_addr <= w_head_addr;
                r_rd_data <= w_head_data;
            end else if (w_sel_pipe) begin
                r_rd_wren <= 1'b1;
                r_rd_addr <= pipe_rd_addr;
                r_rd_data <= pipe_rd_data;
            end else begin
                r_rd_wren <= 1'b0;
            end
        end
    end

    assign busy_rs1 = r_busy[rs1_addr];
    assign busy_rs2 = r_busy[rs2_addr];

    assign rd_wren  = r_rd_wren;
    assign rd_addr  = r_rd_addr;
    assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for the writeback arbiter.
module tb_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        pipe_wren;
    logic [4:0]  pipe_rd_addr;
    logic [31:0] pipe_rd_data;
    logic        pipe_stall;
    logic        mc_issue;
    logic [4:0]  mc_issue_rd;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_rd_addr;
    logic [31:0] mc_rd_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        busy_rs1;
    logic        busy_rs2;
    logic        rd_wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(
        .XLEN       (32),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .pipe_wren    (pipe_wren),
        .pipe_rd_addr (pipe_rd_addr),
        .pipe_rd_data (pipe_rd_data),
        .pipe_stall   (pipe_stall),
        .mc_issue     (mc_issue),
        .mc_issue_rd  (mc_issue_rd),
        .mc_valid     (mc_valid),
        .mc_ready     (mc_ready),
        .mc_rd_addr   (mc_rd_addr),
        .mc_rd_data   (mc_rd_data),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .busy_rs1     (busy_rs1),
        .busy_rs2     (busy_rs2),
        .rd_wren      (rd_wren),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wr_chk(input string tag, input logic en,
                          input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".wren"}, {31'd0, rd_wren}, {31'd0, en});
        if (en) begin
            chk({tag, ".addr"}, {27'd0, rd_addr}, {27'd0, a});
            chk({tag, ".data"}, rd_data, d);
        end
    endtask

    initial begin
        rst_ni       = 1'b0;
        pipe_wren    = 1'b0;
        pipe_rd_addr = '0;
        pipe_rd_data = '0;
        mc_issue     = 1'b0;
        mc_issue_rd  = '0;
        mc_valid     = 1'b0;
        mc_rd_addr   = '0;
        mc_rd_data   = '0;
        rs1_addr     = '0;
        rs2_addr     = '0;
        #1;
        wr_chk("rst", 1'b0, 5'd0, 32'd0);
        chk("rst.addr", {27'd0, rd_addr}, 32'd0);
        chk("rst.data", rd_data, 32'd0);
        chk("rst.ready", {31'd0, mc_ready}, 32'd1);
        chk("rst.stall", {31'd0, pipe_stall}, 32'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        wr_chk("post_rst", 1'b0, 5'd0, 32'd0);

        // Plain pipeline write
        pipe_wren    = 1'b1;
        pipe_rd_addr = 5'd5;
        pipe_rd_data = 32'hDEADBEEF;
        tick();
        pipe_wren = 1'b0;
        wr_chk("pipe5", 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        wr_chk("pipe5.once", 1'b0, 5'd0, 32'd0);

        // Multi-cycle x7 with scoreboard
        mc_issue    = 1'b1;
        mc_issue_rd = 5'd7;
        rs1_addr    = 5'd7;
        chk("busy7.pre", {31'd0, busy_rs1}, 32'd0);
        tick();
        mc_issue = 1'b0;
        chk("busy7.set", {31'd0, busy_rs1}, 32'd1);
        chk("busy.x0", {31'd0, busy_rs2}, 32'd0);
        mc_valid   = 1'b1;
        mc_rd_addr = 5'd7;
        mc_rd_data = 32'h12345678;
        chk("mc7.ready", {31'd0, mc_ready}, 32'd1);
        tick();
        mc_valid = 1'b0;
        wr_chk("mc7.push", 1'b0, 5'd0, 32'd0);
        chk("busy7.hold", {31'd0, busy_rs1}, 32'd1);
        tick();
        wr_chk("mc7.wr", 1'b1, 5'd7, 32'h12345678);
        chk("busy7.clr", {31'd0, busy_rs1}, 32'd0);
        tick();
        wr_chk("mc7.once", 1'b0, 5'd0, 32'd0);

        // Fill buffer while pipeline writes every cycle
        pipe_wren    = 1'b1;
        pipe_rd_addr = 5'd10;
        pipe_rd_data = 32'hA0;
        mc_valid     = 1'b1;
        mc_rd_addr   = 5'd11;
        mc_rd_data   = 32'hB1;
        tick();
        wr_chk("fill.p10", 1'b1, 5'd10, 32'hA0);
        chk("fill.ready1", {31'd0, mc_ready}, 32'd1);
        pipe_rd_addr = 5'd12;
        pipe_rd_data = 32'hA2;
        mc_rd_addr   = 5'd13;
        mc_rd_data   = 32'hB3;
        tick();
        mc_valid = 1'b0;
        wr_chk("fill.p12", 1'b1, 5'd12, 32'hA2);
        chk("full.ready", {31'd0, mc_ready}, 32'd0);
        chk("full.stall", {31'd0, pipe_stall}, 32'd1);
        pipe_rd_addr = 5'd14;
        pipe_rd_data = 32'hA4;
        tick();
        wr_chk("full.head", 1'b1, 5'd11, 32'hB1);
        chk("unfull.stall", {31'd0, pipe_stall}, 32'd0);
        chk("unfull.ready", {31'd0, mc_ready}, 32'd1);
        tick();
        pipe_wren = 1'b0;
        wr_chk("fill.p14", 1'b1, 5'd14, 32'hA4);
        tick();
        wr_chk("drain.13", 1'b1, 5'd13, 32'hB3);
        tick();
        wr_chk("drain.idle", 1'b0, 5'd0, 32'd0);

        // x0 pipe write dropped while x3 drains
        mc_valid     = 1'b1;
        mc_rd_addr   = 5'd3;
        mc_rd_data   = 32'h33;
        pipe_wren    = 1'b1;
        pipe_rd_addr = 5'd0;
        pipe_rd_data = 32'hFF;
        tick();
        mc_valid = 1'b0;
        wr_chk("x0.drop", 1'b0, 5'd0, 32'd0);
        tick();
        wr_chk("x0.x3", 1'b1, 5'd3, 32'h33);
        pipe_wren = 1'b0;
        tick();
        wr_chk("x0.idle", 1'b0, 5'd0, 32'd0);

        // mc result to x0 discarded
        mc_valid   = 1'b1;
        mc_rd_addr = 5'd0;
        mc_rd_data = 32'h99;
        chk("mcx0.ready", {31'd0, mc_ready}, 32'd1);
        tick();
        mc_valid = 1'b0;
        tick();
        wr_chk("mcx0.none", 1'b0, 5'd0, 32'd0);

        // Re-issue x9 in the cycle its entry pops
        mc_issue    = 1'b1;
        mc_issue_rd = 5'd9;
        rs1_addr    = 5'd9;
        tick();
        mc_issue   = 1'b0;
        mc_valid   = 1'b1;
        mc_rd_addr = 5'd9;
        mc_rd_data = 32'h99;
        tick();
        mc_valid    = 1'b0;
        mc_issue    = 1'b1;
        mc_issue_rd = 5'd9;
        tick();
        mc_issue = 1'b0;
        wr_chk("x9.wr", 1'b1, 5'd9, 32'h99);
        chk("x9.busy", {31'd0, busy_rs1}, 32'd1);
        pipe_wren    = 1'b1;
        pipe_rd_addr = 5'd9;
        pipe_rd_data = 32'h5;
        tick();
        pipe_wren = 1'b0;
        wr_chk("x9.pipe", 1'b1, 5'd9, 32'h5);
        chk("x9.busy2", {31'd0, busy_rs1}, 32'd1);

        // Reset while full with pending busy bits
        mc_issue    = 1'b1;
        mc_issue_rd = 5'd21;
        rs1_addr    = 5'd21;
        tick();
        mc_issue     = 1'b0;
        chk("b21.set", {31'd0, busy_rs1}, 32'd1);
        pipe_wren    = 1'b1;
        pipe_rd_addr = 5'd1;
        pipe_rd_data = 32'h11;
        mc_valid     = 1'b1;
        mc_rd_addr   = 5'd22;
        mc_rd_data   = 32'h22;
        tick();
        mc_rd_addr = 5'd23;
        mc_rd_data = 32'h23;
        tick();
        mc_valid = 1'b0;
        chk("pr.stall", {31'd0, pipe_stall}, 32'd1);
        wr_chk("pr.wr", 1'b1, 5'd1, 32'h11);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("ar.wren", {31'd0, rd_wren}, 32'd0);
        chk("ar.addr", {27'd0, rd_addr}, 32'd0);
        chk("ar.data", rd_data, 32'd0);
        chk("ar.ready", {31'd0, mc_ready}, 32'd1);
        chk("ar.stall", {31'd0, pipe_stall}, 32'd0);
        chk("ar.busy", {31'd0, busy_rs1}, 32'd0);
        pipe_wren = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        wr_chk("rel.1", 1'b0, 5'd0, 32'd0);
        tick();
        wr_chk("rel.2", 1'b0, 5'd0, 32'd0);
        chk("rel.busy", {31'd0, busy_rs1}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
